// File: rtl/button_event_pkg.sv
// rtl/button_event_pkg.sv - state encoding shared by the button event classifier
package button_event_pkg;

    localparam int          STATE_W           = 3;
    localparam logic [2:0]  ENC_IDLE          = 3'd0;
    localparam logic [2:0]  ENC_PRESSED       = 3'd1;
    localparam logic [2:0]  ENC_LONG_HELD     = 3'd2;
    localparam logic [2:0]  ENC_WAIT_SECOND   = 3'd3;
    localparam logic [2:0]  ENC_SECOND_HELD   = 3'd4;

    // WAIT_SECOND and SECOND_HELD are only reachable with BUTTON_DOUBLE_CLICK_EN
    typedef enum logic [STATE_W-1:0] {
        ST_IDLE        = ENC_IDLE,
        ST_PRESSED     = ENC_PRESSED,
        ST_LONG_HELD   = ENC_LONG_HELD,
        ST_WAIT_SECOND = ENC_WAIT_SECOND,
        ST_SECOND_HELD = ENC_SECOND_HELD
    } state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/edge_detector.sv
// rtl/edge_detector.sv - rise/fall detection against the previous sampled level
module edge_detector (
    input  logic i_Clk,
    input  logic i_Rst,
    input  logic i_Sig,
    output logic o_Rise,
    output logic o_Fall
);

    logic r_Prev;

    // r_Prev clears on reset so a level already high at release reads as a rise
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            r_Prev <= 1'b0;
        end else begin
            r_Prev <= i_Sig;
        end
    end

    assign o_Rise = i_Sig & ~r_Prev;
    assign o_Fall = ~i_Sig & r_Prev;

endmodule

// File: rtl/button_event_classifier.sv
// rtl/button_event_classifier.sv - press/release/short/long/double-click classifier; BUTTON_DOUBLE_CLICK_EN enables double click
module button_event_classifier
    import button_event_pkg::*;
#(
    parameter int LONG_PRESS_LIMIT    = 250000000,
    parameter int DOUBLE_CLICK_WINDOW = 50000000
) (
    input  logic i_Clk,
    input  logic i_Rst,
    input  logic i_Debounced,
    output logic o_Press,
    output logic o_Release,
    output logic o_Short_Press,
    output logic o_Long_Press,
    output logic o_Double_Click,
    output logic o_Held
);

    localparam int CNT_MAX = max_int(LONG_PRESS_LIMIT, DOUBLE_CLICK_WINDOW);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] CNT_SAT   = CNT_W'(CNT_MAX);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_PRESS_LIMIT - 1);
`ifdef BUTTON_DOUBLE_CLICK_EN
    localparam logic [CNT_W-1:0] DBL_LAST  = CNT_W'(DOUBLE_CLICK_WINDOW - 1);
`endif

    logic rise;
    logic fall;

    edge_detector u_edge (
        .i_Clk  (i_Clk),
        .i_Rst  (i_Rst),
        .i_Sig  (i_Debounced),
        .o_Rise (rise),
        .o_Fall (fall)
    );

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             press_q;
    logic             release_q;
    logic             short_q;
    logic             long_q;
    logic             held_q;
`ifdef BUTTON_DOUBLE_CLICK_EN
    logic             dbl_q;
`endif

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            short_q   <= 1'b0;
            long_q    <= 1'b0;
            held_q    <= 1'b0;
`ifdef BUTTON_DOUBLE_CLICK_EN
            dbl_q     <= 1'b0;
`endif
        end else begin
            press_q   <= 1'b0;
            release_q <= 1'b0;
            short_q   <= 1'b0;
            long_q    <= 1'b0;
`ifdef BUTTON_DOUBLE_CLICK_EN
            dbl_q     <= 1'b0;
`endif
            case (state_q)
                ST_IDLE: begin
                    if (rise) begin
                        state_q <= ST_PRESSED;
                        cnt_q   <= '0;
                        press_q <= 1'b1;
                        held_q  <= 1'b1;
                    end
                end
                ST_PRESSED: begin
                    // release is checked first so a fall on the threshold cycle stays short
                    if (fall) begin
                        cnt_q     <= '0;
                        release_q <= 1'b1;
                        held_q    <= 1'b0;
`ifdef BUTTON_DOUBLE_CLICK_EN
                        state_q   <= ST_WAIT_SECOND;
`else
                        state_q   <= ST_IDLE;
                        short_q   <= 1'b1;
`endif
                    end else if (cnt_q == LONG_LAST) begin
                        state_q <= ST_LONG_HELD;
                        cnt_q   <= '0;
                        long_q  <= 1'b1;
                    end else if (cnt_q != CNT_SAT) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_LONG_HELD: begin
                    if (fall) begin
                        state_q   <= ST_IDLE;
                        cnt_q     <= '0;
                        release_q <= 1'b1;
                        held_q    <= 1'b0;
                    end
                end
`ifdef BUTTON_DOUBLE_CLICK_EN
                ST_WAIT_SECOND: begin
                    if (rise) begin
                        state_q <= ST_SECOND_HELD;
                        cnt_q   <= '0;
                        press_q <= 1'b1;
                        dbl_q   <= 1'b1;
                        held_q  <= 1'b1;
                    end else if (cnt_q == DBL_LAST) begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                        short_q <= 1'b1;
                    end else if (cnt_q != CNT_SAT) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_SECOND_HELD: begin
                    if (fall) begin
                        state_q   <= ST_IDLE;
                        cnt_q     <= '0;
                        release_q <= 1'b1;
                        held_q    <= 1'b0;
                    end
                end
`endif
                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                    held_q  <= 1'b0;
                end
            endcase
        end
    end

    assign o_Press       = press_q;
    assign o_Release     = release_q;
    assign o_Short_Press = short_q;
    assign o_Long_Press  = long_q;
    assign o_Held        = held_q;
`ifdef BUTTON_DOUBLE_CLICK_EN
    assign o_Double_Click = dbl_q;
`else
    assign o_Double_Click = 1'b0;
`endif

endmodule

// File: tb/tb_button_event_classifier.sv
// tb/tb_button_event_classifier.sv - self-checking bench with gesture-level reference model
module tb_button_event_classifier;

    localparam int LP = 8;
    localparam int DW = 6;

    logic clk;
    logic rst;
    logic din;
    logic press, rel, shrt, lng, dbl, held;

    int total = 0;
    int bad   = 0;

    bit         stim[$];
    logic [5:0] got[$];
    logic [5:0] expv[];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    button_event_classifier #(
        .LONG_PRESS_LIMIT    (LP),
        .DOUBLE_CLICK_WINDOW (DW)
    ) dut (
        .i_Clk          (clk),
        .i_Rst          (rst),
        .i_Debounced    (din),
        .o_Press        (press),
        .o_Release      (rel),
        .o_Short_Press  (shrt),
        .o_Long_Press   (lng),
        .o_Double_Click (dbl),
        .o_Held         (held)
    );

    // bit order: {press, release, short, long, double, held}
    function automatic logic [5:0] outs();
        return {press, rel, shrt, lng, dbl, held};
    endfunction

    task automatic push_level(input bit v, input int n);
        for (int i = 0; i < n; i++) stim.push_back(v);
    endtask

    // Expected outputs from press/release gestures: index k is the state just after edge k.
    task automatic build_expected();
        int n;
        int rs[$];
        int fs[$];
        bit second[$];
        n = stim.size();
        expv = new[n];
        foreach (expv[k]) expv[k] = 6'b0;
        for (int k = 0; k < n; k++) begin
            bit prev;
            prev = (k == 0) ? 1'b0 : stim[k-1];
            if (stim[k] && !prev) rs.push_back(k);
            if (!stim[k] && prev) fs.push_back(k);
        end
        if (fs.size() < rs.size()) fs.push_back(n);
        for (int i = 0; i < rs.size(); i++) second.push_back(1'b0);
        for (int i = 0; i < rs.size(); i++) begin
            int r;
            int f;
            r = rs[i];
            f = fs[i];
            expv[r][5] = 1'b1;
            for (int k = r; k < f; k++) expv[k][0] = 1'b1;
            if (f < n) expv[f][4] = 1'b1;
            if (!second[i]) begin
                if (f - r > LP) begin
                    expv[r+LP][2] = 1'b1;
                end else if (f < n) begin
`ifdef BUTTON_DOUBLE_CLICK_EN
                    if (i + 1 < rs.size() && rs[i+1] - f <= DW) begin
                        expv[rs[i+1]][1] = 1'b1;
                        second[i+1] = 1'b1;
                    end else if (f + DW < n) begin
                        expv[f+DW][3] = 1'b1;
                    end
`else
                    expv[f][3] = 1'b1;
`endif
                end
            end
        end
    endtask

    task automatic run_segment(input string name);
        rst = 1'b1;
        din = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        got.delete();
        foreach (stim[k]) begin
            din = stim[k];
            @(posedge clk);
            #1;
            got.push_back(outs());
        end
        build_expected();
        foreach (stim[k]) begin
            total++;
            if (got[k] !== expv[k]) begin
                bad++;
                $display("FAIL %s cycle %0d: got %b expected %b", name, k, got[k], expv[k]);
            end
        end
        stim.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        din = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (outs() !== 6'b0) begin
            bad++;
            $display("FAIL reset_state: got %b expected %b", outs(), 6'b0);
        end
    endtask

    task automatic test_short_press();
        push_level(0, 2); push_level(1, 3); push_level(0, 10);
        run_segment("short_press");
    endtask

    task automatic test_long_press();
        push_level(0, 1); push_level(1, 12); push_level(0, 10);
        run_segment("long_press");
    endtask

    task automatic test_threshold_boundary();
        push_level(1, LP);     push_level(0, 10);
        push_level(1, LP + 1); push_level(0, 10);
        push_level(1, LP - 1); push_level(0, 10);
        run_segment("threshold");
    endtask

    task automatic test_double_click();
        push_level(1, 2); push_level(0, 3);  push_level(1, 2); push_level(0, 10);
        push_level(1, 2); push_level(0, 7);  push_level(1, 2); push_level(0, 10);
        push_level(1, 2); push_level(0, DW); push_level(1, 2); push_level(0, 10);
        push_level(1, 2); push_level(0, 2);  push_level(1, 12); push_level(0, 10);
        run_segment("double_click");
    endtask

    task automatic test_random();
        for (int g = 0; g < 30; g++) begin
            push_level(1, $urandom_range(1, 12));
            push_level(0, $urandom_range(1, 9));
        end
        push_level(0, 12);
        run_segment("random_wide");
        for (int g = 0; g < 30; g++) begin
            push_level(1, $urandom_range(LP - 1, LP + 1));
            push_level(0, $urandom_range(DW - 1, DW + 1));
        end
        push_level(0, 12);
        run_segment("random_edges");
    endtask

    task automatic test_reset_mid_press();
        logic [5:0] exp_rel;
        rst = 1'b1;
        din = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        din = 1'b1;
        repeat (3) @(posedge clk);
        #3;
        total++;
        if (outs() !== 6'b000001) begin
            bad++;
            $display("FAIL mid_press_held: got %b expected %b", outs(), 6'b000001);
        end
        rst = 1'b1;
        #1;
        total++;
        if (outs() !== 6'b0) begin
            bad++;
            $display("FAIL async_reset: got %b expected %b", outs(), 6'b0);
        end
        repeat (LP + 2) @(posedge clk);
        #1;
        total++;
        if (outs() !== 6'b0) begin
            bad++;
            $display("FAIL reset_hold: got %b expected %b", outs(), 6'b0);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if (outs() !== 6'b100001) begin
            bad++;
            $display("FAIL press_after_reset: got %b expected %b", outs(), 6'b100001);
        end
        @(posedge clk);
        #1;
        total++;
        if (outs() !== 6'b000001) begin
            bad++;
            $display("FAIL held_after_reset: got %b expected %b", outs(), 6'b000001);
        end
        din = 1'b0;
        @(posedge clk);
        #1;
`ifdef BUTTON_DOUBLE_CLICK_EN
        exp_rel = 6'b010000;
`else
        exp_rel = 6'b011000;
`endif
        total++;
        if (outs() !== exp_rel) begin
            bad++;
            $display("FAIL release_after_reset: got %b expected %b", outs(), exp_rel);
        end
        repeat (DW + 2) @(posedge clk);
    endtask

    initial begin
        rst = 1'b1;
        din = 1'b0;
        test_reset();
        test_short_press();
        test_long_press();
        test_threshold_boundary();
        test_double_click();
        test_random();
        test_reset_mid_press();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
